cdc_handshake_tx: RTL and testbench
===================================

# cdc_handshake_tx

Source-side half of the team's four-phase req/ack bus synchronizer. Accepts a word through a valid/ready handshake, holds it stable on `o_xdata` and raises `o_xreq` toward a destination clock domain. It then waits for the asynchronous `i_xack`, re-timed internally through a `synch_ff` instance, and completes the four-phase cycle. The destination-side receiver in the other domain samples `o_xdata` after synchronizing `o_xreq`. A timeout counter recovers the source if the destination never answers.

## Interface
- `WIDTH`, 8: payload width in bits.
- `TIMEOUT`, 1024: cycles allowed in each wait state before forced recovery; 0 disables the timeout.
- `i_clk` in 1: source-domain clock; the only clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: upstream word valid.
- `o_ready` out 1: block can accept a word.
- `i_data` in WIDTH: upstream word.
- `o_xdata` out WIDTH: registered payload to the destination domain; stable whenever `o_xreq`=1.
- `o_xreq` out 1: registered request to the destination domain.
- `i_xack` in 1: asynchronous acknowledge from the destination domain.
- `o_done` out 1: one-cycle pulse on normal completion.
- `o_timeout` out 1: one-cycle pulse on each timeout event.
- `o_busy` out 1: high whenever state ≠ IDLE.

## Operation
- `ack_s` is `i_xack` after a 2-stage `synch_ff`; the FSM reads only `ack_s`.
- `o_ready` = (state==IDLE) && !ack_s. A stale high ack blocks acceptance.
- States:
  - IDLE: on `i_valid && o_ready`, capture `i_data` into `o_xdata`, clear the abort flag and go to SETUP.
  - SETUP: one cycle of data setup, then set `o_xreq`=1 and go to REQ.
  - REQ: when `ack_s`=1, clear `o_xreq` and go to DROP. On timeout, clear `o_xreq`, pulse `o_timeout`, set the abort flag and go to DROP.
  - DROP: when `ack_s`=0, go to IDLE and pulse `o_done` only if the abort flag is clear. On timeout, pulse `o_timeout` and go to IDLE with no `o_done`.
- Timeout counter:
  - Width is clog2(TIMEOUT+1).
  - It clears on entry to REQ and to DROP and increments every cycle spent in those states.
  - Timeout fires when the counter equals TIMEOUT-1 and the exit condition is not met in the same cycle. The exit condition takes priority.
- `o_xdata` changes only on acceptance in IDLE; it holds its value through IDLE afterwards.
- Reset values: state IDLE, `o_xreq` 0, `o_xdata` 0, `o_done` 0, `o_timeout` 0, `o_busy` 0, counter 0, abort flag 0.
- Reset mid-transfer: `o_xreq` drops on the reset edge and the transfer is lost, with no `o_done` and no `o_timeout`. `synch_ff` has no reset, so `i_xack` must be driven to a defined level at least 2 cycles before `i_rst` deasserts.

## Timing
- Edge E0 samples the accept condition: `o_xdata` is valid after E0 and `o_xreq` rises after E1.
- Let edge A be the first edge sampling `i_xack`=1. `ack_s` is high after A+1 and `o_xreq` falls after A+2.
- Let edge B be the first edge sampling `i_xack`=0. `ack_s` is low after B+1. After B+2, state is IDLE, `o_done`=1 for that cycle and `o_ready`=1 in that same cycle.
- A back-to-back accept is legal in the `o_done` cycle.
- Minimum source-side overhead per word, excluding destination latency: 2 cycles before request plus 2+2 synchronizer cycles.
- `o_done` and `o_timeout` never assert in the same cycle.

## Structure
- Shared package/include `cdc_hs_pkg`: state encodings (IDLE, SETUP, REQ, DROP) and a clog2 helper function. The destination-side receiver uses the same package.
- One sub-module: the existing `synch_ff` with WIDTH=1 for `i_xack`. No other hierarchy.

## Test plan
- Single word: accept 8'hA5, destination acks 3 cycles after seeing req and drops ack 3 cycles after req falls -> `o_xdata`=A5 stable throughout `o_xreq`=1, exactly one `o_done`, `o_ready` high in the same cycle.
- Back-to-back: `i_valid` held high with words 01..10 -> 16 `o_done` pulses, words delivered in order, `o_xreq` never high while `o_xdata` changes.
- Ack never arrives, TIMEOUT=16: `o_timeout` 16 cycles after entering REQ, `o_xreq` falls, IDLE reached once `ack_s`=0, no `o_done`.
- Ack stuck high: `o_ready` stays 0 in IDLE, and a timeout in DROP returns the FSM to IDLE with a second `o_timeout` pulse.
- Reset asserted while in REQ with `i_xack`=1 -> next cycle `o_xreq`=0, `o_busy`=0, `o_xdata`=0, no pulses.
- TIMEOUT=0 with ack delayed 5000 cycles -> no `o_timeout`, normal `o_done`.

Source files
------------

// File: rtl/cdc_hs_pkg.sv
// Shared definitions for the four-phase req/ack bus synchronizer (source and destination halves).
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        DROP  = 2'd3
    } hs_state_t;

    localparam int unsigned SYNC_STAGES = 2;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'(1) << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/synch_ff.sv
// Multi-stage flip-flop synchronizer for asynchronous level signals; no reset by design.
module synch_ff #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge i_clk) begin
        sync_q[0] <= i_d;
        for (int i = 1; i < int'(STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
        end
    end

    assign o_q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source half of the four-phase req/ack synchronizer: captures a word, raises o_xreq,
// follows the re-timed ack through the full handshake and recovers on a wait timeout.
module cdc_handshake_tx
    import cdc_hs_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_xdata,
    output logic             o_xreq,
    input  logic             i_xack,
    output logic             o_done,
    output logic             o_timeout,
    output logic             o_busy
);

    localparam int unsigned CNT_RAW = clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W   = (CNT_RAW == 0) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    hs_state_t        state;
    logic             ack_s;
    logic [CNT_W-1:0] tmo_cnt;
    logic             abort_q;
    logic             tmo_hit_c;

    synch_ff #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .i_clk (i_clk),
        .i_d   (i_xack),
        .o_q   (ack_s)
    );

    // A stale acknowledge from a previous word must clear before a new one is taken.
    assign o_ready   = (state == IDLE) && !ack_s;
    assign tmo_hit_c = (TIMEOUT != 0) && (tmo_cnt == CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            o_xreq    <= 1'b0;
            o_xdata   <= '0;
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
            o_busy    <= 1'b0;
            tmo_cnt   <= '0;
            abort_q   <= 1'b0;
        end else begin
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        o_xdata <= i_data;
                        abort_q <= 1'b0;
                        o_busy  <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    o_xreq  <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= REQ;
                end
                REQ: begin
                    if (ack_s) begin
                        o_xreq  <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= DROP;
                    end else if (tmo_hit_c) begin
                        o_xreq    <= 1'b0;
                        o_timeout <= 1'b1;
                        abort_q   <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= DROP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                DROP: begin
                    // Exit on ack release wins over a coincident timeout.
                    if (!ack_s) begin
                        o_done <= !abort_q;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else if (tmo_hit_c) begin
                        o_timeout <= 1'b1;
                        o_busy    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    o_xreq <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: timing derived from the handshake rules, scoreboard of words.
module tb_cdc_handshake_tx;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    // Instance A: TIMEOUT=16
    logic       a_valid, a_ready, a_xreq, a_xack, a_done, a_timeout, a_busy;
    logic [7:0] a_data, a_xdata;
    // Instance B: timeout disabled
    logic       b_valid, b_ready, b_xreq, b_xack, b_done, b_timeout, b_busy;
    logic [7:0] b_data, b_xdata;

    cdc_handshake_tx #(.WIDTH(8), .TIMEOUT(16)) dut_a (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (a_valid),
        .o_ready   (a_ready),
        .i_data    (a_data),
        .o_xdata   (a_xdata),
        .o_xreq    (a_xreq),
        .i_xack    (a_xack),
        .o_done    (a_done),
        .o_timeout (a_timeout),
        .o_busy    (a_busy)
    );

    cdc_handshake_tx #(.WIDTH(8), .TIMEOUT(0)) dut_b (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (b_valid),
        .o_ready   (b_ready),
        .i_data    (b_data),
        .o_xdata   (b_xdata),
        .o_xreq    (b_xreq),
        .i_xack    (b_xack),
        .o_done    (b_done),
        .o_timeout (b_timeout),
        .o_busy    (b_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] a_sent [$];
    logic [7:0] a_rx   [$];
    int exp_done_a = 0;
    int exp_to_a   = 0;
    int a_done_n = 0, a_to_n = 0, a_both_n = 0, a_unstable_n = 0;
    int b_done_n = 0, b_to_n = 0;
    logic       a_prev_req = 1'b0;
    logic [7:0] a_prev_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Pulse counts and payload stability observed independently of the stimulus.
    always @(negedge i_clk) begin
        if (a_done) a_done_n++;
        if (a_timeout) a_to_n++;
        if (a_done && a_timeout) a_both_n++;
        if (a_xreq && a_prev_req && (a_xdata != a_prev_data)) a_unstable_n++;
        if (a_xreq && !a_prev_req) a_rx.push_back(a_xdata);
        a_prev_req  = a_xreq;
        a_prev_data = a_xdata;
        if (b_done) b_done_n++;
        if (b_timeout) b_to_n++;
    end

    task automatic wait_ready_a(output bit ok);
        int n;
        n = 0;
        while (!a_ready && n < 64) begin
            @(negedge i_clk);
            n++;
        end
        ok = a_ready;
    endtask

    // One complete handshake on instance A; destination reacts ack_dly / drop_dly cycles late.
    task automatic xfer_a(input logic [7:0] d, input int ack_dly, input int drop_dly,
                          input bit hold, input logic [7:0] nxt);
        bit ok;
        wait_ready_a(ok);
        chk("ready_wait", 32'(ok), 1);
        if (!ok) return;
        a_valid = 1'b1;
        a_data  = d;
        a_sent.push_back(d);
        tick(1);
        chk("xdata_acc", a_xdata, d);
        chk("xreq_setup", a_xreq, 0);
        chk("busy_acc", a_busy, 1);
        a_valid = hold;
        a_data  = nxt;
        tick(1);
        chk("xreq_rise", a_xreq, 1);
        chk("ready_req", a_ready, 0);
        tick(ack_dly);
        a_xack = 1'b1;
        tick(2);
        chk("xreq_hold", a_xreq, 1);
        tick(1);
        chk("xreq_fall", a_xreq, 0);
        tick(drop_dly);
        a_xack = 1'b0;
        tick(2);
        chk("done_early", a_done, 0);
        chk("busy_drop", a_busy, 1);
        tick(1);
        chk("done", a_done, 1);
        chk("ready_done", a_ready, 1);
        chk("busy_done", a_busy, 0);
        exp_done_a++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int n;
        i_rst = 1'b1;
        a_valid = 1'b0; a_data = 8'h00; a_xack = 1'b0;
        b_valid = 1'b0; b_data = 8'h00; b_xack = 1'b0;
        tick(5);
        i_rst = 1'b0;
        tick(1);
        chk("rst_xreq", a_xreq, 0);
        chk("rst_xdata", a_xdata, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_timeout", a_timeout, 0);
        chk("rst_ready", a_ready, 1);

        // Single word with 3-cycle destination response each way
        xfer_a(8'hA5, 3, 3, 1'b0, 8'h00);
        tick(2);

        // Back-to-back: valid held high, words 01..10
        for (int i = 1; i <= 16; i++) begin
            xfer_a(8'(i), int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
                   (i < 16), 8'(i + 1));
        end
        tick(3);

        // Random words with random gaps
        for (int i = 0; i < 6; i++) begin
            xfer_a(8'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                   1'b0, 8'($urandom));
            tick(int'($urandom_range(0, 3)));
        end

        // Ack never arrives: REQ timeout after 16 cycles, then straight back to IDLE
        wait_ready_a(ok);
        chk("to_ready", 32'(ok), 1);
        a_valid = 1'b1; a_data = 8'h5A; a_sent.push_back(8'h5A);
        tick(1);
        a_valid = 1'b0;
        tick(1);
        chk("to_xreq_rise", a_xreq, 1);
        tick(15);
        chk("to_early", a_timeout, 0);
        chk("to_xreq_held", a_xreq, 1);
        tick(1);
        chk("to_pulse", a_timeout, 1);
        chk("to_xreq_fall", a_xreq, 0);
        exp_to_a++;
        tick(1);
        chk("to_idle_busy", a_busy, 0);
        chk("to_no_done", a_done, 0);
        chk("to_ready_back", a_ready, 1);
        chk("to_pulse_end", a_timeout, 0);
        tick(2);

        // Ack arrives too late for REQ, then sticks high: REQ and DROP both time out
        wait_ready_a(ok);
        a_valid = 1'b1; a_data = 8'hC3; a_sent.push_back(8'hC3);
        tick(1);
        a_valid = 1'b0;
        tick(1);
        chk("stk_xreq_rise", a_xreq, 1);
        tick(14);
        a_xack = 1'b1;
        tick(2);
        chk("stk_req_to", a_timeout, 1);
        chk("stk_xreq_fall", a_xreq, 0);
        tick(15);
        chk("stk_drop_wait", a_busy, 1);
        chk("stk_drop_early", a_timeout, 0);
        tick(1);
        chk("stk_drop_to", a_timeout, 1);
        chk("stk_drop_idle", a_busy, 0);
        chk("stk_no_done", a_done, 0);
        chk("stk_ready_blk", a_ready, 0);
        exp_to_a += 2;
        a_valid = 1'b1; a_data = 8'h77;
        tick(8);
        chk("stk_no_accept", a_busy, 0);
        chk("stk_ready_still", a_ready, 0);
        a_valid = 1'b0;
        a_xack  = 1'b0;
        tick(1);
        chk("stk_ready_sync", a_ready, 0);
        tick(1);
        chk("stk_ready_free", a_ready, 1);
        tick(2);

        // Reset in REQ with ack high: transfer dropped silently
        wait_ready_a(ok);
        a_valid = 1'b1; a_data = 8'h96; a_sent.push_back(8'h96);
        tick(1);
        a_valid = 1'b0;
        tick(1);
        chk("rr_xreq_rise", a_xreq, 1);
        a_xack = 1'b1;
        tick(1);
        chk("rr_in_req", a_xreq, 1);
        i_rst = 1'b1;
        tick(1);
        chk("rr_xreq", a_xreq, 0);
        chk("rr_busy", a_busy, 0);
        chk("rr_xdata", a_xdata, 0);
        chk("rr_done", a_done, 0);
        chk("rr_timeout", a_timeout, 0);
        a_xack = 1'b0;
        tick(3);
        i_rst = 1'b0;
        tick(1);
        chk("rr_ready", a_ready, 1);
        chk("rr_busy_after", a_busy, 0);
        tick(3);

        // Timeout disabled: 5000-cycle ack delay completes normally
        n = 0;
        while (!b_ready && n < 64) begin tick(1); n++; end
        chk("b_ready", b_ready, 1);
        b_valid = 1'b1; b_data = 8'h3C;
        tick(1);
        chk("b_xdata", b_xdata, 8'h3C);
        b_valid = 1'b0;
        tick(1);
        chk("b_xreq_rise", b_xreq, 1);
        tick(5000);
        chk("b_xreq_long", b_xreq, 1);
        chk("b_busy_long", b_busy, 1);
        b_xack = 1'b1;
        tick(3);
        chk("b_xreq_fall", b_xreq, 0);
        b_xack = 1'b0;
        tick(3);
        chk("b_done", b_done, 1);
        chk("b_ready_done", b_ready, 1);
        tick(2);
        chk("b_done_n", b_done_n, 1);
        chk("b_timeout_n", b_to_n, 0);

        // Scoreboard
        chk("a_done_n", a_done_n, exp_done_a);
        chk("a_timeout_n", a_to_n, exp_to_a);
        chk("a_done_and_to", a_both_n, 0);
        chk("a_xdata_stable", a_unstable_n, 0);
        chk("a_rx_len", a_rx.size(), a_sent.size());
        for (int i = 0; i < a_sent.size() && i < a_rx.size(); i++) begin
            chk($sformatf("a_word%0d", i), a_rx[i], a_sent[i]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
